// File: rtl/mac_lookup_if.sv
// Handshake bundle between the MAC lookup controller, the frame parser
// (req/res) and the hash-table search engine (se_*).
interface mac_lookup_if;
    logic        req_valid;
    logic        req_ready;
    logic [47:0] req_sa;
    logic [47:0] req_da;
    logic [3:0]  req_inport;

    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_portmap;
    logic        res_flood;

    logic        se_req;
    logic        se_source;
    logic [47:0] se_mac;
    logic [9:0]  se_hash;
    logic [15:0] se_portmap;
    logic        se_ack;
    logic        se_nak;
    logic [15:0] se_result;

    modport master (
        input  req_valid, req_sa, req_da, req_inport, res_ready,
               se_ack, se_nak, se_result,
        output req_ready, res_valid, res_portmap, res_flood,
               se_req, se_source, se_mac, se_hash, se_portmap
    );

    modport slave (
        output req_valid, req_sa, req_da, req_inport, res_ready,
               se_ack, se_nak, se_result,
        input  req_ready, res_valid, res_portmap, res_flood,
               se_req, se_source, se_mac, se_hash, se_portmap
    );
endinterface

// File: rtl/mac_lookup_ctrl.sv
// MAC learn/lookup sequencer: learns the SA, looks up the DA in the hash
// table, returns an egress port map, and requests periodic aging sweeps.
module mac_lookup_ctrl #(
    parameter logic [31:0] AGE_PERIOD = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    mac_lookup_if.master bus,
    output logic        aging_req,
    input  logic        aging_ack,
    output logic [15:0] learn_fail_cnt,
    output logic [15:0] miss_cnt
);

    typedef enum logic [1:0] {IDLE, LEARN, LOOK, RESP} state_t;

    state_t      state;
    logic [47:0] da_q;
    logic [3:0]  inport_q;
    logic        se_req_q, se_source_q;
    logic [47:0] se_mac_q;
    logic [9:0]  se_hash_q;
    logic [15:0] se_portmap_q;
    logic        res_valid_q, res_flood_q;
    logic [15:0] res_portmap_q;
    logic [15:0] lf_q, miss_q;
    logic [31:0] age_timer;
    logic        aging_req_q;

    function automatic logic [9:0] mac_hash(input logic [47:0] m);
        return m[9:0] ^ m[19:10] ^ m[29:20] ^ m[39:30] ^ {2'b0, m[47:40]};
    endfunction

    function automatic logic [15:0] excl(input logic [3:0] p);
        return 16'hFFFF & ~(16'h1 << p);
    endfunction

    // In IDLE the DA path works from the live request, elsewhere from the latch.
    logic [47:0] da_sel;
    logic [3:0]  inport_sel;
    logic        se_done;

    assign da_sel     = (state == IDLE) ? bus.req_da     : da_q;
    assign inport_sel = (state == IDLE) ? bus.req_inport : inport_q;
    assign se_done    = se_req_q & (bus.se_ack | bus.se_nak);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            da_q          <= '0;
            inport_q      <= '0;
            se_req_q      <= 1'b0;
            se_source_q   <= 1'b0;
            se_mac_q      <= '0;
            se_hash_q     <= '0;
            se_portmap_q  <= '0;
            res_valid_q   <= 1'b0;
            res_flood_q   <= 1'b0;
            res_portmap_q <= '0;
            lf_q          <= '0;
            miss_q        <= '0;
        end else begin
            case (state)
                IDLE, LEARN: begin
                    if (state == IDLE && bus.req_valid) begin
                        da_q     <= bus.req_da;
                        inport_q <= bus.req_inport;
                    end
                    if (state == IDLE && bus.req_valid && !bus.req_sa[40]) begin
                        state        <= LEARN;
                        se_req_q     <= 1'b1;
                        se_source_q  <= 1'b1;
                        se_mac_q     <= bus.req_sa;
                        se_hash_q    <= mac_hash(bus.req_sa);
                        se_portmap_q <= 16'h1 << bus.req_inport;
                    end else if ((state == IDLE && bus.req_valid) || (state == LEARN && se_done)) begin
                        se_req_q <= 1'b0;
                        if (state == LEARN && bus.se_nak && lf_q != 16'hFFFF)
                            lf_q <= lf_q + 16'd1;
                        if (da_sel[40]) begin
                            state         <= RESP;
                            res_valid_q   <= 1'b1;
                            res_flood_q   <= 1'b1;
                            res_portmap_q <= excl(inport_sel);
                        end else begin
                            // Enter LOOK with se_req low; it rises a cycle later.
                            state        <= LOOK;
                            se_source_q  <= 1'b0;
                            se_mac_q     <= da_sel;
                            se_hash_q    <= mac_hash(da_sel);
                            se_portmap_q <= '0;
                        end
                    end
                end
                LOOK: begin
                    if (!se_req_q) begin
                        se_req_q <= 1'b1;
                    end else if (se_done) begin
                        se_req_q    <= 1'b0;
                        state       <= RESP;
                        res_valid_q <= 1'b1;
                        if (bus.se_nak) begin
                            res_flood_q   <= 1'b1;
                            res_portmap_q <= excl(inport_q);
                            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
                        end else begin
                            res_flood_q   <= 1'b0;
                            res_portmap_q <= bus.se_result & excl(inport_q);
                        end
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Aging timer freezes while a sweep is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_timer   <= '0;
            aging_req_q <= 1'b0;
        end else if (aging_req_q) begin
            if (aging_ack) begin
                aging_req_q <= 1'b0;
                age_timer   <= '0;
            end
        end else if (age_timer == AGE_PERIOD - 32'd1) begin
            age_timer   <= '0;
            aging_req_q <= 1'b1;
        end else begin
            age_timer <= age_timer + 32'd1;
        end
    end

    assign bus.req_ready   = (state == IDLE) & ~rst;
    assign bus.res_valid   = res_valid_q & ~rst;
    assign bus.res_flood   = res_flood_q & ~rst;
    assign bus.res_portmap = res_portmap_q & {16{~rst}};
    assign bus.se_req      = se_req_q & ~rst;
    assign bus.se_source   = se_source_q & ~rst;
    assign bus.se_mac      = se_mac_q & {48{~rst}};
    assign bus.se_hash     = se_hash_q & {10{~rst}};
    assign bus.se_portmap  = se_portmap_q & {16{~rst}};
    assign aging_req       = aging_req_q & ~rst;
    assign learn_fail_cnt  = lf_q & {16{~rst}};
    assign miss_cnt        = miss_q & {16{~rst}};

endmodule

// File: tb/tb_mac_lookup_ctrl.sv
// Scoreboard bench for mac_lookup_ctrl: a search-engine responder plus
// expected-result queue, with directed aging and reset scenarios.
module tb_mac_lookup_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aging_req, aging_ack;
    logic [15:0] learn_fail_cnt, miss_cnt;

    mac_lookup_if bus();

    mac_lookup_ctrl #(.AGE_PERIOD(32'd8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .aging_req(aging_req), .aging_ack(aging_ack),
        .learn_fail_cnt(learn_fail_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pm;
        logic        fl;
    } res_t;

    res_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_lf = '0;
    logic [15:0] exp_miss = '0;
    bit          saw_both;

    function automatic logic [9:0] ref_hash(input logic [47:0] m);
        logic [49:0] w;
        logic [9:0]  h;
        w = {2'b00, m};
        h = '0;
        for (int i = 0; i < 5; i++) h = h ^ w[i*10 +: 10];
        return h;
    endfunction

    task automatic run_frame(input logic [47:0] sa, input logic [47:0] da, input logic [3:0] inport,
                             input bit lrn_nak, input bit look_nak, input logic [15:0] se_res,
                             input int ack_dly, input int hold);
        res_t        e;
        logic [15:0] self_bit, pm0;
        bit          learned, looked, done;
        int          n, w;
        self_bit = 16'h1 << inport;
        if (da[40] || look_nak) e = '{pm: 16'hFFFF & ~self_bit, fl: 1'b1};
        else                    e = '{pm: se_res & ~self_bit, fl: 1'b0};
        sb.push_back(e);
        if (!sa[40] && lrn_nak) exp_lf++;
        if (!da[40] && look_nak) exp_miss++;

        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (!bus.req_ready) begin miscompares++; $display("FAIL req_ready_timeout got=0 want=1"); end
        bus.req_valid = 1'b1; bus.req_sa = sa; bus.req_da = da; bus.req_inport = inport;
        @(negedge clk);
        bus.req_valid = 1'b0;

        learned = 0; looked = 0; done = 0; n = 0; w = 0;
        while (!done && n < 100) begin
            n++;
            if (bus.se_req) begin
                if (aging_req) saw_both = 1;
                vectors++;
                if (bus.se_source) begin
                    if ({bus.se_mac, bus.se_hash, bus.se_portmap} !== {sa, ref_hash(sa), self_bit}) begin
                        miscompares++;
                        $display("FAIL learn_req got=%h/%h/%h want=%h/%h/%h", bus.se_mac, bus.se_hash,
                                 bus.se_portmap, sa, ref_hash(sa), self_bit);
                    end
                end else begin
                    if ({bus.se_mac, bus.se_hash, bus.se_portmap} !== {da, ref_hash(da), 16'h0}) begin
                        miscompares++;
                        $display("FAIL look_req got=%h/%h/%h want=%h/%h/0000", bus.se_mac, bus.se_hash,
                                 bus.se_portmap, da, ref_hash(da));
                    end
                end
                if (w < ack_dly) begin
                    w++;
                    @(negedge clk);
                end else begin
                    w = 0;
                    if (bus.se_source) begin
                        learned = 1; bus.se_ack = !lrn_nak; bus.se_nak = lrn_nak;
                    end else begin
                        looked = 1; bus.se_ack = !look_nak; bus.se_nak = look_nak; bus.se_result = se_res;
                    end
                    @(negedge clk);
                    bus.se_ack = 1'b0; bus.se_nak = 1'b0;
                end
            end else if (bus.res_valid) begin
                pm0 = bus.res_portmap;
                for (int i = 0; i < hold; i++) begin
                    vectors++;
                    if (!bus.res_valid || bus.res_portmap !== pm0 || bus.req_ready) begin
                        miscompares++;
                        $display("FAIL backpressure_hold got=%b/%h/%b want=1/%h/0", bus.res_valid,
                                 bus.res_portmap, bus.req_ready, pm0);
                    end
                    @(negedge clk);
                end
                e = sb.pop_front();
                vectors++;
                if ({bus.res_portmap, bus.res_flood} !== {e.pm, e.fl}) begin
                    miscompares++;
                    $display("FAIL result got=%h/%b want=%h/%b", bus.res_portmap, bus.res_flood, e.pm, e.fl);
                end
                bus.res_ready = 1'b1;
                @(negedge clk);
                bus.res_ready = 1'b0;
                vectors++;
                if (bus.res_valid !== 1'b0) begin
                    miscompares++; $display("FAIL res_valid_drop got=%b want=0", bus.res_valid);
                end
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        vectors++;
        if (!done || learned !== !sa[40] || looked !== !da[40]) begin
            miscompares++;
            $display("FAIL frame_flow got=done%0d/learn%0d/look%0d want=1/%0d/%0d",
                     done, learned, looked, !sa[40], !da[40]);
        end
        vectors++;
        if ({learn_fail_cnt, miss_cnt} !== {exp_lf, exp_miss}) begin
            miscompares++;
            $display("FAIL counters got=%0d/%0d want=%0d/%0d", learn_fail_cnt, miss_cnt, exp_lf, exp_miss);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.req_ready, bus.res_valid, bus.res_portmap, bus.res_flood, bus.se_req, bus.se_source,
             bus.se_mac, bus.se_hash, bus.se_portmap, aging_req, learn_fail_cnt, miss_cnt} !== '0) begin
            miscompares++; $display("FAIL reset_outputs got=nonzero want=all zero");
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready got=%b want=1", bus.req_ready);
        end
        exp_lf = '0; exp_miss = '0;
    endtask

    task automatic test_aging();
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_lf = '0; exp_miss = '0;
        n = 0;
        while (!aging_req && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (n != 8) begin miscompares++; $display("FAIL aging_first_rise got=%0d want=8", n); end
        // Multicast DA frame runs while the sweep is outstanding.
        saw_both = 0;
        run_frame(48'h0000_0000_1234, 48'h0100_0000_0000, 4'd7, 0, 0, 16'h0, 0, 0);
        vectors++;
        if (!saw_both || aging_req !== 1'b1) begin
            miscompares++; $display("FAIL aging_concurrent got=%0d/%b want=1/1", saw_both, aging_req);
        end
        aging_ack = 1'b1;
        @(negedge clk);
        aging_ack = 1'b0;
        vectors++;
        if (aging_req !== 1'b0) begin miscompares++; $display("FAIL aging_fall got=%b want=0", aging_req); end
        n = 0;
        while (!aging_req && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (n != 8) begin miscompares++; $display("FAIL aging_second_rise got=%0d want=8", n); end
    endtask

    task automatic test_known_da();
        run_frame(48'h0000_0000_0401, 48'h0000_1234_5678, 4'd3, 0, 0, 16'h0030, 0, 0);
    endtask

    task automatic test_unknown_da();
        run_frame(48'h0000_00AB_CDEF, 48'h0000_0BAD_F00D, 4'd0, 0, 1, 16'h0, 0, 0);
    endtask

    task automatic test_mcast_da();
        run_frame(48'h0000_0000_0002, 48'h0100_0000_0000, 4'd12, 0, 0, 16'h0, 0, 0);
    endtask

    task automatic test_self_forward();
        run_frame(48'h0000_0000_0803, 48'h0000_0000_0777, 4'd3, 0, 0, 16'h0008, 0, 0);
    endtask

    task automatic test_learn_fail_bp();
        run_frame(48'h00AA_5555_0001, 48'h0000_0000_0123, 4'd5, 1, 0, 16'h00F0, 2, 5);
    endtask

    task automatic test_mcast_sa();
        run_frame(48'h0100_0000_0001, 48'h0000_0000_0555, 4'd9, 0, 0, 16'hFFFF, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [47:0] sa, da;
        for (int i = 0; i < 6; i++) begin
            sa = {$urandom, $urandom};
            da = {$urandom, $urandom};
            run_frame(sa, da, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), 16'($urandom), 0, 0);
        end
    endtask

    task automatic test_reset_in_look();
        int n;
        bus.req_valid = 1'b1; bus.req_sa = 48'h0000_0000_0101; bus.req_da = 48'h0000_0000_0202;
        bus.req_inport = 4'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!(bus.se_req && bus.se_source) && n < 20) begin @(negedge clk); n++; end
        bus.se_ack = 1'b1;
        @(negedge clk);
        bus.se_ack = 1'b0;
        n = 0;
        while (!(bus.se_req && !bus.se_source) && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 20) begin miscompares++; $display("FAIL look_reached got=timeout want=se_req"); end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.se_req, bus.res_valid, bus.req_ready} !== 3'b000) begin
            miscompares++; $display("FAIL reset_in_look got=%b%b%b want=000", bus.se_req, bus.res_valid, bus.req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.se_req !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_idle got=%b/%b want=1/0", bus.req_ready, bus.se_req);
        end
        bus.se_ack = 1'b1; bus.se_result = 16'h00FF;
        @(negedge clk);
        bus.se_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                miscompares++; $display("FAIL stray_ack got=%b/%b want=0/1", bus.res_valid, bus.req_ready);
            end
            @(negedge clk);
        end
        vectors++;
        if ({learn_fail_cnt, miss_cnt} !== 32'h0) begin
            miscompares++; $display("FAIL counters_cleared got=%0d/%0d want=0/0", learn_fail_cnt, miss_cnt);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_sa = '0; bus.req_da = '0; bus.req_inport = '0;
        bus.res_ready = 1'b0; bus.se_ack = 1'b0; bus.se_nak = 1'b0; bus.se_result = '0;
        aging_ack = 1'b0;
        test_reset();
        test_aging();
        test_known_da();
        test_unknown_da();
        test_mcast_da();
        test_self_forward();
        test_learn_fail_bp();
        test_mcast_sa();
        test_back_to_back();
        test_reset_in_look();
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mac_lookup_ctrl.md
MAC_LOOKUP_CTRL -- requirements
Module: mac_lookup_ctrl

Interface
REQ-001 The block SHALL have parameter AGE_PERIOD, default 32'd1_000_000, giving the number of clk cycles between aging sweeps.
REQ-002 The block SHALL have these ports; all signals run on one clock, and reset is synchronous and active-high:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  frame header available.
- req_ready  out  1  block idle and able to accept a header.
- req_sa  in  48  source MAC.
- req_da  in  48  destination MAC.
- req_inport  in  4  ingress port number.
- res_valid  out  1  forwarding result valid.
- res_ready  in  1  result consumed.
- res_portmap  out  16  egress port map.
- res_flood  out  1  result is a flood.
- se_req  out  1  hash-table request, level signal.
- se_source  out  1  1 = learn SA, 0 = lookup DA.
- se_mac  out  48  MAC under search.
- se_hash  out  10  bucket index.
- se_portmap  out  16  portmap to learn.
- se_ack  in  1  one-cycle pulse: success.
- se_nak  in  1  one-cycle pulse: miss, or learn with no free slot.
- se_result  in  16  portmap found, valid with se_ack on a lookup.
- aging_req  out  1  level signal; hold until aging_ack.
- aging_ack  in  1  one-cycle pulse: aging sweep complete.
- learn_fail_cnt  out  16  count of learn NAKs, saturating.
- miss_cnt  out  16  count of lookup NAKs, saturating.

Function
REQ-003 The block SHALL compute hash(m) = m[9:0] ^ m[19:10] ^ m[29:20] ^ m[39:30] ^ {2'b0, m[47:40]}, purely combinationally.
REQ-004 The state machine SHALL have four states: IDLE, LEARN, LOOK, RESP.
REQ-005 req_ready SHALL be 1 only when the state is IDLE and rst is 0.
REQ-006 When the state is IDLE and req_valid is 1, the block SHALL:
- latch req_sa, req_da and req_inport;
- if req_sa[40] is 0, go to LEARN;
- if req_sa[40] is 1 (multicast SA), skip learning and take the DA path of REQ-009.
REQ-007 In LEARN the block SHALL drive:
- se_req = 1, se_source = 1;
- se_mac = SA, se_hash = hash(SA);
- se_portmap = 16'h1 << inport.
REQ-008 In LEARN and LOOK, se_req, se_source, se_mac, se_hash and se_portmap SHALL remain stable until the cycle in which se_ack or se_nak is sampled high.
REQ-009 At the edge that samples se_ack or se_nak in LEARN, the block SHALL:
- deassert se_req, registered, so that se_req is 0 in the next cycle;
- if se_nak is 1, increment learn_fail_cnt;
- take the DA path: if DA[40] is 1, go to RESP with res_flood = 1 and res_portmap = 16'hFFFF & ~(1 << inport); otherwise go to LOOK.
REQ-010 Once deasserted, se_req SHALL remain 0 for at least one full cycle before the block asserts it again.
REQ-011 In LOOK the block SHALL drive se_req = 1, se_source = 0, se_mac = DA, se_hash = hash(DA), se_portmap = 0.
REQ-012 When se_ack is sampled in LOOK, the block SHALL set res_portmap = se_result & ~(1 << inport) and res_flood = 0, then go to RESP; a resulting value of 0 means the frame is filtered.
REQ-013 When se_nak is sampled in LOOK, the block SHALL set res_flood = 1, set res_portmap = 16'hFFFF & ~(1 << inport), increment miss_cnt, then go to RESP.
REQ-014 If se_ack and se_nak are high together, the block SHALL treat the pair as se_nak.
REQ-015 In RESP the block SHALL hold res_valid = 1 with res_portmap and res_flood stable until res_valid and res_ready are both 1; it SHALL then return to IDLE.
REQ-016 res_valid SHALL be 0 in the first IDLE cycle after RESP.
REQ-017 learn_fail_cnt and miss_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-018 The aging timer SHALL be a 32-bit counter that increments every cycle while aging_req is 0.
REQ-019 When the aging timer equals AGE_PERIOD-1, the block SHALL clear the timer and set aging_req = 1 on the next edge.
REQ-020 aging_req SHALL remain 1 until aging_ack is sampled; the block SHALL then clear aging_req and restart the timer from 0.
REQ-021 While aging_req is 1, the aging timer SHALL hold its value.
REQ-022 aging_req and se_req SHALL be independent: the block SHALL NOT gate se_req on aging activity, because the hash table gives se_req priority.
REQ-023 An se_ack or se_nak arriving in IDLE or RESP SHALL be ignored.

Reset
REQ-024 While rst is 1, the block SHALL force state = IDLE and clear the aging timer.
REQ-025 While rst is 1, the block SHALL drive all of these outputs to 0: req_ready, res_valid, res_portmap, res_flood, se_req, se_source, se_mac, se_hash, se_portmap, aging_req, learn_fail_cnt, miss_cnt.
REQ-026 A reset applied in any state, including mid-handshake, SHALL take effect at the next edge; the block SHALL discard the in-flight request and SHALL NOT emit a result for it.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Known DA: SA = 48'h0000_0000_0401, inport = 3; expect se_hash = 10'h000 and se_portmap = 16'h0008. Model replies ack; DA lookup replies ack with se_result = 16'h0030. Expect res_portmap = 16'h0030 and res_flood = 0.
- Unknown DA, inport = 0: DA lookup replies nak. Expect res_flood = 1, res_portmap = 16'hFFFE, miss_cnt = 1.
- DA = 48'h0100_0000_0000 (bit 40 set): expect no LOOK request, and res_portmap = 16'hFFFF & ~(1 << inport) with res_flood = 1.
- Self-forward: se_result = 16'h0008 with inport = 3. Expect res_portmap = 0.
- Learn failure and result backpressure: learn replies nak. Expect learn_fail_cnt = 1. Hold res_ready = 0 for 5 cycles; expect res_valid and res_portmap stable throughout, and req_ready = 0.
- Aging with AGE_PERIOD = 8: expect aging_req to rise 8 cycles after reset and stay high through a concurrent se_req; pulse aging_ack; expect aging_req to fall next cycle and rise again 8 cycles later.
- Reset in LOOK: expect se_req = 0 and state IDLE next cycle; a later ack pulse produces no res_valid.
